apx_err_monitor: RTL

- Streaming error-statistics collector. Sits directly downstream of the approximate adders (bta, bta_trunc) and the exact acc_adder.
- Consumes pairs of one approximate result and one exact result over a window of WIN samples.
- Accumulates these error metrics: sample count, error count, error-distance sum and maximum error distance.
- Presents the metrics through a valid/ready report interface. This replaces offline file dumps when characterising a given NAB setting in hardware.

---
 rtl/apx_err_pkg.sv | 10 +
 rtl/apx_abs_diff.sv | 18 +
 rtl/apx_err_monitor.sv | 123 ++++++++++++
 3 files changed

// File: rtl/apx_err_pkg.sv
// apx_err_pkg: shared state encoding, default widths and sizing helper for the error monitor.
package apx_err_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DRAIN = 2'd2, RPT = 2'd3} state_t;
  localparam int DEF_W = 32;
  localparam int DEF_CW = 16;
  localparam int DEF_SW = DEF_W + DEF_CW;
  function automatic int sat_add_w(input int w);
    return w + 1;
  endfunction
endpackage

// File: rtl/apx_abs_diff.sv
// apx_abs_diff: combinational |approx - exact| in W bits, signed or unsigned operands.
module apx_abs_diff #(
  parameter int W = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic [W-1:0] approx,
  input  logic [W-1:0] exact,
  output logic [W-1:0] ed
);
  logic [W:0] a, e, d;
  always_comb begin
    a = {SIGNED ? approx[W-1] : 1'b0, approx};
    e = {SIGNED ? exact[W-1] : 1'b0, exact};
    d = a - e;
    // |d| never exceeds 2**W-1, so dropping the top bit is lossless
    ed = d[W] ? W'(-d) : d[W-1:0];
  end
endmodule

// File: rtl/apx_err_monitor.sv
// apx_err_monitor: windowed error statistics (count, error count, distance sum/max) for approximate adders.
// Define APX_ERR_SQ_EN to add a squared-distance sum (err_sq_sum) with one extra pipeline stage.
module apx_err_monitor
  import apx_err_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int WIN = 5000,
  parameter int CW = DEF_CW,
  parameter int SW = DEF_SW,
  parameter bit SIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  approx,
  input  logic [W-1:0]  exact,
  output logic          busy,
  output logic          rpt_valid,
  input  logic          rpt_ready,
  output logic [CW-1:0] sample_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [SW-1:0] err_sum,
  output logic [W-1:0]  err_max
`ifdef APX_ERR_SQ_EN
  ,
  output logic [2*W+CW-1:0] err_sq_sum
`endif
);
  localparam int SAW = sat_add_w(SW);
  if (WIN >= 2**CW) begin : g_win_chk
    $error("apx_err_monitor: WIN must be below 2**CW");
  end
  state_t state;
  logic [CW-1:0] acc_cnt;
  logic [W-1:0] ed, ed1, eds;
  logic v1, vs, pending, xfer, clr;
  logic [SAW-1:0] sum_ext;
  assign in_ready = state == ACC;
  assign busy = state != IDLE;
  assign rpt_valid = state == RPT;
  assign xfer = in_valid && in_ready;
  assign clr = state == IDLE && start;
  assign sum_ext = SAW'(err_sum) + SAW'(eds);
  apx_abs_diff #(.W(W), .SIGNED(SIGNED)) u_abs (
    .approx(approx),
    .exact(exact),
    .ed(ed)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      ed1 <= '0;
    end else begin
      v1 <= xfer;
      if (xfer) ed1 <= ed;
    end
  end
`ifdef APX_ERR_SQ_EN
  localparam int QW = 2*W + CW;
  localparam int QAW = sat_add_w(QW);
  logic v1b;
  logic [W-1:0] ed1b;
  logic [2*W-1:0] sq1b;
  logic [QAW-1:0] sq_ext;
  assign vs = v1b;
  assign eds = ed1b;
  assign pending = v1 || v1b;
  assign sq_ext = QAW'(err_sq_sum) + QAW'(sq1b);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1b <= 1'b0;
      ed1b <= '0;
      sq1b <= '0;
      err_sq_sum <= '0;
    end else begin
      v1b <= v1;
      if (v1) begin
        ed1b <= ed1;
        sq1b <= (2*W)'(ed1) * (2*W)'(ed1);
      end
      if (clr) err_sq_sum <= '0;
      else if (vs) err_sq_sum <= sq_ext[QAW-1] ? '1 : sq_ext[QW-1:0];
    end
  end
`else
  assign vs = v1;
  assign eds = ed1;
  assign pending = v1;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc_cnt <= '0;
      sample_cnt <= '0;
      err_cnt <= '0;
      err_sum <= '0;
      err_max <= '0;
    end else if (clr) begin
      state <= ACC;
      acc_cnt <= '0;
      sample_cnt <= '0;
      err_cnt <= '0;
      err_sum <= '0;
      err_max <= '0;
    end else begin
      // samples still in flight keep landing while DRAIN empties the pipeline
      if (vs) begin
        sample_cnt <= sample_cnt + CW'(1);
        err_cnt <= err_cnt + CW'(eds != '0);
        err_sum <= sum_ext[SAW-1] ? '1 : sum_ext[SW-1:0];
        err_max <= eds > err_max ? eds : err_max;
      end
      if (xfer) begin
        acc_cnt <= acc_cnt + CW'(1);
        if (acc_cnt == CW'(WIN - 1)) state <= DRAIN;
      end
      if (state == DRAIN && !pending) state <= RPT;
      if (state == RPT && rpt_ready) state <= IDLE;
    end
  end
endmodule
